// File: rtl/hls_launch_pkg.sv
// Shared types and constants for the HLS kernel launcher: FSM states,
// completion status codes, AXI response and ap_ctrl bit positions.
package hls_launch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_RESP,
        S_POLL_WAIT,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_e;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BUSERR  = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    localparam int AP_START = 0;
    localparam int AP_DONE  = 1;

endpackage

// File: rtl/hls_pr_kernel_launcher.sv
// AXI-Lite master that writes HLS kernel arguments, sets ap_start, polls
// ap_ctrl for ap_done (with timeout) and returns a tagged completion.
module hls_pr_kernel_launcher
    import hls_launch_pkg::*;
#(
    parameter int          NUM_ARGS   = 4,
    parameter logic [31:0] CTRL_BASE  = 32'h0000_0000,
    parameter logic [31:0] ARG_OFFSET = 32'h10,
    parameter logic [31:0] ARG_STRIDE = 32'h8,
    parameter int          POLL_GAP   = 16,
    parameter logic [31:0] TIMEOUT    = 32'd1_000_000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [NUM_ARGS*32-1:0] cmd_args,
    input  logic [7:0]            cmd_tag,

    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [7:0]            done_tag,
    output logic [1:0]            done_status,
    output logic                  busy,

    output logic [31:0]           m_axi_lite_awaddr,
    output logic [2:0]            m_axi_lite_awprot,
    output logic                  m_axi_lite_awvalid,
    input  logic                  m_axi_lite_awready,
    output logic [31:0]           m_axi_lite_wdata,
    output logic [3:0]            m_axi_lite_wstrb,
    output logic                  m_axi_lite_wvalid,
    input  logic                  m_axi_lite_wready,
    input  logic [1:0]            m_axi_lite_bresp,
    input  logic                  m_axi_lite_bvalid,
    output logic                  m_axi_lite_bready,
    output logic [31:0]           m_axi_lite_araddr,
    output logic [2:0]            m_axi_lite_arprot,
    output logic                  m_axi_lite_arvalid,
    input  logic                  m_axi_lite_arready,
    input  logic [31:0]           m_axi_lite_rdata,
    input  logic [1:0]            m_axi_lite_rresp,
    input  logic                  m_axi_lite_rvalid,
    output logic                  m_axi_lite_rready
);

    if (NUM_ARGS < 1 || NUM_ARGS > 8) begin : g_bad_num_args
        $error("hls_pr_kernel_launcher: NUM_ARGS must be in 1..8");
    end

    localparam logic [31:0] START_WORD = 32'(1) << AP_START;

    state_e                  state_q, state_d;
    logic [NUM_ARGS*32-1:0]  args_q, args_d;
    logic [7:0]              tag_q, tag_d;
    logic [1:0]              status_q, status_d;
    logic [3:0]              idx_q, idx_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [15:0]             poll_q, poll_d;
    logic [31:0]             tmo_q, tmo_d;

    logic                    last_write;
    logic [31:0]             arg_word;
    logic                    aw_hs, w_hs;
    logic [31:0]             tmo_inc;
    logic                    unused_rdata;

    assign last_write = (idx_q == 4'(NUM_ARGS));
    assign aw_hs      = m_axi_lite_awvalid && m_axi_lite_awready;
    assign w_hs       = m_axi_lite_wvalid && m_axi_lite_wready;
    // Saturate so a stuck kernel can never wrap the counter back below TIMEOUT.
    assign tmo_inc    = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;
    assign unused_rdata = ^{m_axi_lite_rdata[31:AP_DONE+1], m_axi_lite_rdata[AP_DONE-1:0]};

    always_comb begin
        arg_word = '0;
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (idx_q == 4'(i)) begin
                arg_word = args_q[i*32 +: 32];
            end
        end
    end

    assign cmd_ready          = (state_q == S_IDLE) && !sys_rst;
    assign busy               = (state_q != S_IDLE);
    assign done_valid         = (state_q == S_DONE);
    assign done_tag           = tag_q;
    assign done_status        = status_q;

    assign m_axi_lite_awaddr  = last_write ? CTRL_BASE
                                           : CTRL_BASE + ARG_OFFSET + 32'(idx_q) * ARG_STRIDE;
    assign m_axi_lite_awprot  = 3'b000;
    assign m_axi_lite_awvalid = (state_q == S_WR_ADDR) && !aw_done_q;
    assign m_axi_lite_wdata   = last_write ? START_WORD : arg_word;
    assign m_axi_lite_wstrb   = 4'hF;
    assign m_axi_lite_wvalid  = (state_q == S_WR_ADDR) && !w_done_q;
    assign m_axi_lite_bready  = (state_q == S_WR_RESP);
    assign m_axi_lite_araddr  = CTRL_BASE;
    assign m_axi_lite_arprot  = 3'b000;
    assign m_axi_lite_arvalid = (state_q == S_RD_ADDR);
    assign m_axi_lite_rready  = (state_q == S_RD_DATA);

    always_comb begin
        state_d   = state_q;
        args_d    = args_q;
        tag_d     = tag_q;
        status_d  = status_q;
        idx_d     = idx_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        poll_d    = poll_q;
        tmo_d     = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    args_d    = cmd_args;
                    tag_d     = cmd_tag;
                    idx_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_RESP;
                end else begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                end
            end
            S_WR_RESP: begin
                if (m_axi_lite_bvalid) begin
                    if (m_axi_lite_bresp != AXI_OKAY) begin
                        status_d = ST_BUSERR;
                        state_d  = S_DONE;
                    end else if (!last_write) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_WR_ADDR;
                    end else begin
                        tmo_d   = '0;
                        poll_d  = '0;
                        state_d = S_POLL_WAIT;
                    end
                end
            end
            S_POLL_WAIT: begin
                tmo_d = tmo_inc;
                if (tmo_q >= TIMEOUT) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end else if (poll_q == 16'(POLL_GAP - 1)) begin
                    poll_d  = '0;
                    state_d = S_RD_ADDR;
                end else begin
                    poll_d = poll_q + 16'd1;
                end
            end
            S_RD_ADDR: begin
                tmo_d = tmo_inc;
                if (m_axi_lite_arready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                tmo_d = tmo_inc;
                // The read always completes before a timeout is reported.
                if (m_axi_lite_rvalid) begin
                    if (m_axi_lite_rresp != AXI_OKAY) begin
                        status_d = ST_BUSERR;
                        state_d  = S_DONE;
                    end else if (m_axi_lite_rdata[AP_DONE]) begin
                        status_d = ST_OK;
                        state_d  = S_DONE;
                    end else if (tmo_q >= TIMEOUT) begin
                        status_d = ST_TIMEOUT;
                        state_d  = S_DONE;
                    end else begin
                        poll_d  = '0;
                        state_d = S_POLL_WAIT;
                    end
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            args_q    <= '0;
            tag_q     <= '0;
            status_q  <= ST_OK;
            idx_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            poll_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            args_q    <= args_d;
            tag_q     <= tag_d;
            status_q  <= status_d;
            idx_q     <= idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            poll_q    <= poll_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule

// File: tb/tb_hls_pr_kernel_launcher.sv
// Self-checking bench for hls_pr_kernel_launcher: a reactive AXI-Lite slave
// model, a table of launch vectors and hand-written reset/backpressure runs.
module tb_hls_pr_kernel_launcher;
    import hls_launch_pkg::*;

    localparam int NA = 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          cmd_valid, cmd_ready;
    logic [NA*32-1:0] cmd_args;
    logic [7:0]    cmd_tag;
    logic          done_valid, done_ready;
    logic [7:0]    done_tag;
    logic [1:0]    done_status;
    logic          busy;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [2:0]    awprot, arprot;
    logic [3:0]    wstrb;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;

    always #5 sys_clk = ~sys_clk;

    hls_pr_kernel_launcher #(
        .NUM_ARGS(NA), .CTRL_BASE(32'h0), .ARG_OFFSET(32'h10), .ARG_STRIDE(32'h8),
        .POLL_GAP(16), .TIMEOUT(32'd200)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_args(cmd_args), .cmd_tag(cmd_tag),
        .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag),
        .done_status(done_status), .busy(busy),
        .m_axi_lite_awaddr(awaddr), .m_axi_lite_awprot(awprot), .m_axi_lite_awvalid(awvalid),
        .m_axi_lite_awready(awready), .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb),
        .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready), .m_axi_lite_bresp(bresp),
        .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready), .m_axi_lite_araddr(araddr),
        .m_axi_lite_arprot(arprot), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
        .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
        .m_axi_lite_rready(rready)
    );

    typedef struct {
        logic [63:0] args;
        logic [7:0]  tag;
        int          awD;
        int          wD;
        int          errI;
        int          doneOn;
        logic [1:0]  expStatus;
        int          expWrites;
        int          expReads;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] tag;
        logic [1:0] status;
    } done_t;

    int    total = 0;
    int    bad   = 0;
    vec_t  vecs [6];
    wr_t   expWr [$];
    done_t expDone [$];

    // Slave configuration, written only by the main process.
    int   awDelay, wDelay, errIdx, doneOnRead;
    logic slvClear;

    // Slave state, written only by the slave process.
    logic        awGot, wGot, rPend;
    int          awCnt, wCnt, bCnt, rdCount, awExtra, wExtra, protBad;
    logic [31:0] curAddr, curData;
    logic [31:0] obsAddr [16];
    logic [31:0] obsData [16];

    // Reactive AXI-Lite slave: capture handshakes at the edge, then drive.
    always @(posedge sys_clk) begin
        if (sys_rst || slvClear) begin
            awGot = 0; wGot = 0; rPend = 0;
            awCnt = 0; wCnt = 0; bCnt = 0; rdCount = 0;
            awExtra = 0; wExtra = 0; protBad = 0;
        end else begin
            if (awvalid && awready) begin
                curAddr = awaddr; awGot = 1; awCnt = 0;
                if (awprot != 3'b000) protBad++;
            end
            if (wvalid && wready) begin
                curData = wdata; wGot = 1; wCnt = 0;
                if (wstrb != 4'hF) protBad++;
            end
            if (bvalid && bready) begin
                if (bCnt < 16) begin
                    obsAddr[bCnt] = curAddr;
                    obsData[bCnt] = curData;
                end
                bCnt++; awGot = 0; wGot = 0;
            end
            if (arvalid && arready) begin
                rdCount++; rPend = 1;
                if (araddr != 32'h0 || arprot != 3'b000) protBad++;
            end
            if (rvalid && rready) rPend = 0;
        end
        #1;
        if (sys_rst) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        end else begin
            if (awvalid && awGot) awExtra++;
            if (wvalid && wGot) wExtra++;
            awready = 0;
            if (awvalid && !awGot) begin
                if (awCnt >= awDelay) awready = 1;
                else awCnt++;
            end
            wready = 0;
            if (wvalid && !wGot) begin
                if (wCnt >= wDelay) wready = 1;
                else wCnt++;
            end
            bvalid  = awGot && wGot;
            bresp   = (bCnt == errIdx) ? 2'b10 : 2'b00;
            arready = arvalid && !rPend;
            rvalid  = rPend;
            rresp   = 2'b00;
            rdata   = (doneOnRead != 0 && rdCount >= doneOnRead) ? 32'h6 : 32'h1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addrModel(input int i);
        return (i < NA) ? 32'h10 + 32'(i) * 32'h8 : 32'h0;
    endfunction

    function automatic logic [31:0] dataModel(input logic [63:0] a, input int i);
        return (i < NA) ? a[i*32 +: 32] : 32'h1;
    endfunction

    task automatic applyStimulus(input vec_t v);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge sys_clk); #2; n++;
        end
        checkOutput("cmd_ready_before_launch", 64'(cmd_ready), 64'd1);
        awDelay = v.awD; wDelay = v.wD; errIdx = v.errI; doneOnRead = v.doneOn;
        slvClear = 1;
        @(posedge sys_clk); #2;
        slvClear = 0;
        for (int i = 0; i < v.expWrites; i++)
            expWr.push_back('{addr: addrModel(i), data: dataModel(v.args, i)});
        expDone.push_back('{tag: v.tag, status: v.expStatus});
        cmd_args  = v.args;
        cmd_tag   = v.tag;
        cmd_valid = 1;
        @(posedge sys_clk); #2;
        cmd_valid = 0;
    endtask

    // Waits for done_valid; compares tag/status against the scoreboard head.
    task automatic waitDone(output bit found);
        done_t e;
        int n;
        found = 0;
        n = 0;
        while (!done_valid && n < 2000) begin
            @(posedge sys_clk); #2; n++;
        end
        if (!done_valid) begin
            checkOutput("done_valid_within_budget", 64'd0, 64'd1);
            return;
        end
        found = 1;
        e = expDone.pop_front();
        checkOutput("done_tag", 64'(done_tag), 64'(e.tag));
        checkOutput("done_status", 64'(done_status), 64'(e.status));
    endtask

    task automatic checkBus(input vec_t v);
        wr_t w;
        checkOutput("b_count", 64'(bCnt), 64'(v.expWrites));
        for (int i = 0; i < v.expWrites; i++) begin
            w = expWr.pop_front();
            if (i < 16) begin
                checkOutput($sformatf("wr%0d_addr", i), 64'(obsAddr[i]), 64'(w.addr));
                checkOutput($sformatf("wr%0d_data", i), 64'(obsData[i]), 64'(w.data));
            end
        end
        checkOutput("read_count", 64'(rdCount), 64'(v.expReads));
        checkOutput("aw_valid_after_hs", 64'(awExtra), 64'd0);
        checkOutput("w_valid_after_hs", 64'(wExtra), 64'd0);
        checkOutput("prot_strb_araddr", 64'(protBad), 64'd0);
        checkOutput("no_open_read", 64'({rPend, arvalid, rvalid}), 64'd0);
    endtask

    task automatic runVector(input vec_t v);
        bit found;
        applyStimulus(v);
        waitDone(found);
        if (found) begin
            @(posedge sys_clk); #2;
            checkBus(v);
            checkOutput("idle_after_done", 64'({cmd_ready, busy, done_valid}), 64'b100);
        end
    endtask

    initial begin
        bit   found;
        int   n;
        vec_t v;
        sys_rst = 1; cmd_valid = 0; cmd_args = '0; cmd_tag = '0; done_ready = 1;
        slvClear = 0; awDelay = 0; wDelay = 0; errIdx = -1; doneOnRead = 0;

        repeat (3) @(posedge sys_clk);
        #2;
        checkOutput("reset_outputs",
            64'({cmd_ready, busy, done_valid, done_status, done_tag,
                 awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        sys_rst = 0;
        @(posedge sys_clk); #2;
        checkOutput("post_reset_ready", 64'({cmd_ready, busy}), 64'b10);

        vecs[0] = '{64'h0000_1000_A5A5_0000, 8'h3C, 0, 0, -1, 3, ST_OK,      3, 3};
        vecs[1] = '{64'h1111_2222_3333_4444, 8'h11, 5, 0, -1, 1, ST_OK,      3, 1};
        vecs[2] = '{64'hDEAD_BEEF_0BAD_F00D, 8'h22, 0, 5, -1, 2, ST_OK,      3, 2};
        vecs[3] = '{64'hCAFE_0001_CAFE_0000, 8'h33, 0, 0,  1, 3, ST_BUSERR,  2, 0};
        vecs[4] = '{64'h0000_00FF_0000_00EE, 8'h44, 2, 3,  2, 3, ST_BUSERR,  3, 0};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 8'h55, 0, 0, -1, 0, ST_TIMEOUT, 3, 11};

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d tag %0h", i, vecs[i].tag);
            runVector(vecs[i]);
        end

        // Asynchronous reset while waiting on a write response.
        v = '{64'h0000_0002_0000_0001, 8'h77, 0, 0, -1, 1, ST_OK, 3, 1};
        applyStimulus(v);
        n = 0;
        while (!bready && n < 100) begin
            @(posedge sys_clk); #2; n++;
        end
        checkOutput("reached_wr_resp", 64'(bready), 64'd1);
        #1 sys_rst = 1;
        #1;
        checkOutput("async_reset_wr_resp",
            64'({cmd_ready, busy, done_valid, done_status, done_tag,
                 awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        expWr.delete();
        expDone.delete();
        @(posedge sys_clk); #2;
        sys_rst = 0;
        @(posedge sys_clk); #2;
        checkOutput("ready_after_reset", 64'(cmd_ready), 64'd1);
        runVector('{64'h0BAD_CAFE_1234_0000, 8'h78, 1, 1, -1, 2, ST_OK, 3, 2});

        // Completion backpressure: outputs hold while done_ready is low.
        done_ready = 0;
        v = '{64'h0000_0000_FFFF_FFFF, 8'h9C, 0, 0, -1, 1, ST_OK, 3, 1};
        applyStimulus(v);
        waitDone(found);
        if (found) begin
            for (int c = 0; c < 10; c++) begin
                @(posedge sys_clk); #2;
                checkOutput($sformatf("bp_hold_%0d", c),
                    64'({done_valid, done_tag, done_status, cmd_ready}),
                    64'({1'b1, 8'h9C, ST_OK, 1'b0}));
            end
            done_ready = 1;
            #1;
            checkOutput("bp_ready_before_hs", 64'(cmd_ready), 64'd0);
            @(posedge sys_clk); #2;
            checkOutput("bp_after_hs", 64'({done_valid, cmd_ready}), 64'b01);
            checkBus(v);
        end

        // Reset while a completion is stalled in DONE.
        done_ready = 0;
        applyStimulus('{64'h0000_0005_0000_0006, 8'h5A, 0, 0, 0, 1, ST_BUSERR, 1, 0});
        waitDone(found);
        #1 sys_rst = 1;
        #1;
        checkOutput("async_reset_done",
            64'({done_valid, done_tag, done_status, busy, cmd_ready}), 64'd0);
        expWr.delete();
        expDone.delete();
        done_ready = 1;
        @(posedge sys_clk); #2;
        sys_rst = 0;
        @(posedge sys_clk); #2;
        checkOutput("ready_after_done_reset", 64'(cmd_ready), 64'd1);
        runVector('{64'h4444_3333_2222_1111, 8'hE1, 0, 0, -1, 1, ST_OK, 3, 1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
